memoria_responder: RTL and testbench
====================================

// Module: memoria_responder
// PURPOSE
//   Main-memory responder for the L1 cache: accepts one read (miss fill) or write
//   (dirty write-back) request at a time over a req/ready handshake, models a fixed
//   access latency, then returns a one-cycle ack with read data. Sits between the
//   cache controller and the 32x8 main storage array.
// PARAMETERS
//   ADDR_W   5   address width (words = 2**ADDR_W)
//   DATA_W   8   data word width
//   LATENCY  3   access cycles from accept to ack; legal range 1..15
// PORTS
//   clock_in      in   1        single clock, rising edge
//   reset_n_in    in   1        asynchronous, active-low reset
//   req_in        in   1        request valid
//   wren_in       in   1        1 = write (write-back), 0 = read (fill)
//   endereco_in   in   ADDR_W   request address
//   data_in       in   DATA_W   write data
//   flip_par_in   in   1        test hook: store inverted parity on this write
//   ready_out     out  1        responder idle, request may be accepted
//   ack_out       out  1        one-cycle completion pulse
//   q_out         out  DATA_W   read data (or echoed write data), held until next ack
//   err_out       out  1        parity error on the acked read
// BEHAVIOUR
//   - Reset (async, reset_n_in=0): state IDLE, ready_out=1, ack_out=0, q_out=0,
//     err_out=0, latency counter=0. Storage contents NOT cleared by reset;
//     power-up contents mem[a]=a.
//   - FSM IDLE -> ACCESS -> RESPOND -> IDLE.
//     IDLE: ready_out=1. Accept on edge with req_in=1: latch wren/addr/data/flip,
//       load counter LATENCY-1, go ACCESS.
//     ACCESS: ready_out=0; counter decrements each edge; on the edge with counter==0
//       perform access (write commits to array; read captures word) and go RESPOND.
//     RESPOND: ack_out=1 for exactly this cycle, q_out/err_out valid; next edge IDLE.
//   - Latency: ack_out high in the cycle following the LATENCY-th edge after the
//     accept edge. Occupancy LATENCY+1 cycles; next accept no earlier than the
//     second edge after ack.
//   - req_in while ready_out=0 is ignored (not queued); requester holds req_in until
//     it sees ready_out=1 at an edge.
//   - Write ack: q_out = written data, err_out=0. Read ack: q_out = stored word.
//   - q_out, err_out hold value between acks; ack_out never two consecutive cycles.
//   - Read of an address written by the immediately preceding request returns the
//     new data (write committed before RESPOND).
//   - Reset mid-operation: request aborted, no ack; a write not yet committed is lost,
//     an already committed write stays.
//   - Addresses wrap naturally modulo 2**ADDR_W; no out-of-range case.
// CONFIGURATION
//   MEM_PARITY_EN defined: array stores DATA_W+1 bits, even parity computed on write
//     (inverted when latched flip_par_in=1); checked on read, err_out=1 on mismatch
//     during the read ack cycle.
//   MEM_PARITY_EN undefined: no parity storage, flip_par_in ignored, err_out tied 0.
// STRUCTURE
//   Package memoria_pkg: ADDR_W/DATA_W defaults, state enum {IDLE, ACCESS, RESPOND},
//     even-parity function.
//   Sub-module memoria_array: synchronous single-port RAM, 2**ADDR_W x (DATA_W[+1]),
//     power-up init mem[a]=a; FSM and counter stay in memoria_responder.
// TESTING
//   1 Reset, then read addr 5 (LATENCY=3) -> ack_out high 3 edges after accept,
//     q_out=8'd5, ready_out low 4 cycles.
//   2 Write 8'hA7 to addr 12, then read addr 12 -> write ack q_out=8'hA7; read ack
//     q_out=8'hA7, err_out=0.
//   3 Hold req_in=1 continuously for 3 reads (addr 1,2,3 changed on each accept) ->
//     exactly 3 single-cycle acks, q_out 1,2,3, no request accepted while busy.
//   4 Write 8'h3C to addr 7, assert reset_n_in=0 during ACCESS, release, read addr 7
//     -> no ack for aborted write, read returns 8'd7; repeat with reset during
//     RESPOND -> read returns 8'h3C.
//   5 MEM_PARITY_EN: write 8'h01 addr 9 with flip_par_in=1, read addr 9 -> err_out=1
//     on ack; rewrite with flip_par_in=0, read -> err_out=0. Without macro err_out=0.
//   6 LATENCY=1 build: read addr 31 -> ack in cycle after first edge post-accept,
//     q_out=8'd31.

Source files
------------

// File: rtl/memoria_pkg.sv
// Shared types and helpers for the main-memory responder.
// Optional parity storage is enabled by defining MEM_PARITY_EN.
package memoria_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Reduction XOR: the parity bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

    // Width of one stored word; one extra bit when parity is kept.
    function automatic int word_width(input int data_w);
`ifdef MEM_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/memoria_array.sv
// Synchronous single-port main storage, 2**ADDR_W words, power-up mem[a]=a.
// With MEM_PARITY_EN the top bit of each word holds its even-parity bit.
module memoria_array
    import memoria_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WORD_W = word_width(DATA_W)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef logic [WORD_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t              m;
        logic [DATA_W-1:0] v;
        for (int a = 0; a < DEPTH; a++) begin
            v = DATA_W'(a);
`ifdef MEM_PARITY_EN
            m[a] = {even_parity(32'(v)), v};
`else
            m[a] = v;
`endif
        end
        return m;
    endfunction

    // Contents come from the declaration initialiser and are never touched by reset.
    mem_t mem = init_mem();

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/memoria_responder.sv
// Main-memory responder: one request at a time, fixed LATENCY (1..15), one-cycle ack.
// MEM_PARITY_EN adds stored even parity and err_out reporting on read acks.
module memoria_responder
    import memoria_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = 3
) (
    input  logic              clock_in,
    input  logic              reset_n_in,
    input  logic              req_in,
    input  logic              wren_in,
    input  logic [ADDR_W-1:0] endereco_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              flip_par_in,
    output logic              ready_out,
    output logic              ack_out,
    output logic [DATA_W-1:0] q_out,
    output logic              err_out,
    output state_t            state_out
);

    localparam int WORD_W = word_width(DATA_W);

    // Handshake: a request is taken on a rising edge where req_in=1 and
    // ready_out=1; req_in seen while ready_out=0 is simply ignored.

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   q_hold;
    logic                err_hold;
    logic                mem_en;
    logic                accept;
    logic [WORD_W-1:0]   wr_word;
    logic [WORD_W-1:0]   rd_word;
    logic [DATA_W-1:0]   resp_data;
    logic                resp_err;

    assign accept    = (state_q == IDLE) && req_in;
    assign state_out = state_q;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_out = 1'b0;
        ack_out   = 1'b0;
        mem_en    = 1'b0;
        case (state_q)
            IDLE: begin
                ready_out = 1'b1;
                if (req_in) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    mem_en  = 1'b1;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: begin
                ack_out = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_PARITY_EN
    logic flip_q;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            flip_q <= 1'b0;
        end else if (accept) begin
            flip_q <= flip_par_in;
        end
    end

    assign wr_word  = {even_parity(32'(data_q)) ^ flip_q, data_q};
    assign resp_err = !wr_q && (^rd_word);
`else
    logic unused_flip;

    assign unused_flip = flip_par_in;
    assign wr_word     = data_q;
    assign resp_err    = 1'b0;
`endif

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            wr_q   <= wren_in;
            addr_q <= endereco_in;
            data_q <= data_in;
        end
    end

    memoria_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) u_array (
        .clk   (clock_in),
        .en    (mem_en),
        .we    (wr_q),
        .addr  (addr_q),
        .wdata (wr_word),
        .rdata (rd_word)
    );

    // The array read register is only meaningful during RESPOND, so the visible
    // result is muxed live then and copied into the hold register on leaving it.
    assign resp_data = wr_q ? data_q : rd_word[DATA_W-1:0];

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            q_hold   <= '0;
            err_hold <= 1'b0;
        end else if (state_q == RESPOND) begin
            q_hold   <= resp_data;
            err_hold <= resp_err;
        end
    end

    assign q_out   = (state_q == RESPOND) ? resp_data : q_hold;
    assign err_out = (state_q == RESPOND) ? resp_err  : err_hold;

endmodule

// File: tb/tb_memoria_responder.sv
// Directed bench for memoria_responder: LATENCY=3 main instance plus a LATENCY=1 instance.
// Parity expectations follow MEM_PARITY_EN.
module tb_memoria_responder;
    import memoria_pkg::*;

    localparam int LAT = 3;
`ifdef MEM_PARITY_EN
    localparam logic PAR_EXP = 1'b1;
`else
    localparam logic PAR_EXP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (LATENCY=3) ----------------
    logic       req = 1'b0, wren = 1'b0, flip = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] din = '0;
    logic       ready, ack, err;
    logic [7:0] q;
    state_t     state;

    memoria_responder #(.ADDR_W(5), .DATA_W(8), .LATENCY(LAT)) u_dut (
        .clock_in    (clk),
        .reset_n_in  (rst_n),
        .req_in      (req),
        .wren_in     (wren),
        .endereco_in (addr),
        .data_in     (din),
        .flip_par_in (flip),
        .ready_out   (ready),
        .ack_out     (ack),
        .q_out       (q),
        .err_out     (err),
        .state_out   (state)
    );

    // ---------------- DUT (LATENCY=1) ----------------
    logic       req1 = 1'b0, wren1 = 1'b0, flip1 = 1'b0;
    logic [4:0] addr1 = '0;
    logic [7:0] din1 = '0;
    logic       ready1, ack1, err1;
    logic [7:0] q1;
    state_t     state1;

    memoria_responder #(.ADDR_W(5), .DATA_W(8), .LATENCY(1)) u_dut_l1 (
        .clock_in    (clk),
        .reset_n_in  (rst_n),
        .req_in      (req1),
        .wren_in     (wren1),
        .endereco_in (addr1),
        .data_in     (din1),
        .flip_par_in (flip1),
        .ready_out   (ready1),
        .ack_out     (ack1),
        .q_out       (q1),
        .err_out     (err1),
        .state_out   (state1)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    int          ack_cnt  = 0;
    logic        prev_ack = 1'b0;

    always @(negedge clk) begin
        if (ack) begin
            ack_cnt++;
            check("ack_spacing", 32'(prev_ack), 32'd0);
            check("ack_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("q_out", 32'(q), exp_q.pop_front());
                check("err_out", 32'(err), 32'(exp_err_q.pop_front()));
            end
        end
        prev_ack = ack;
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        req  = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic txn(input logic w, input logic [4:0] a, input logic [7:0] d,
                       input logic f, input logic [7:0] eq, input logic ee,
                       input string tag);
        int k;
        int busy;
        @(negedge clk);
        req  = 1'b1;
        wren = w;
        addr = a;
        din  = d;
        flip = f;
        exp_q.push_back(32'(eq));
        exp_err_q.push_back(ee);
        @(posedge clk);
        #1 req = 1'b0;
        k    = 0;
        busy = 0;
        @(negedge clk);
        if (!ready) busy++;
        while (!ack && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (!ready) busy++;
        end
        check({tag, "_latency"}, 32'(k), 32'(LAT));
        check({tag, "_busy_cycles"}, 32'(busy), 32'(LAT + 1));
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(ready), 32'd1);
        check({tag, "_ack_single"}, 32'(ack), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int ack_before;
        int acc[4];

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        rst_n = 1'b1;

        // 1: read power-up contents, then q_out holds
        txn(1'b0, 5'd5, 8'h00, 1'b0, 8'd5, 1'b0, "rd5");
        repeat (3) @(negedge clk);
        check("q_hold", 32'(q), 32'd5);

        // 2: write then read back
        txn(1'b1, 5'd12, 8'hA7, 1'b0, 8'hA7, 1'b0, "wr12");
        txn(1'b0, 5'd12, 8'h00, 1'b0, 8'hA7, 1'b0, "rd12");

        // 3: req_in held high for three back-to-back reads
        ack_before = ack_cnt;
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(32'(i));
            exp_err_q.push_back(1'b0);
        end
        req  = 1'b1;
        wren = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            addr = 5'(i);
            t = 0;
            while (!ready && t < 30) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            #1 acc[i] = cyc;
            if (i == 3) req = 1'b0;
        end
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("hold_req_acks", 32'(ack_cnt - ack_before), 32'd3);
        check("hold_req_gap12", 32'(acc[2] - acc[1]), 32'(LAT + 2));
        check("hold_req_gap23", 32'(acc[3] - acc[2]), 32'(LAT + 2));

        // 4a: reset during ACCESS drops the uncommitted write
        ack_before = ack_cnt;
        @(negedge clk);
        req  = 1'b1;
        wren = 1'b1;
        addr = 5'd7;
        din  = 8'h3C;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_state", 32'(state), 32'(IDLE));
        rst_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        check("abort_no_ack", 32'(ack_cnt - ack_before), 32'd0);
        txn(1'b0, 5'd7, 8'h00, 1'b0, 8'd7, 1'b0, "rd7_lost");

        // 4b: reset during RESPOND keeps the committed write
        @(negedge clk);
        req  = 1'b1;
        wren = 1'b1;
        addr = 5'd7;
        din  = 8'h3C;
        exp_q.push_back(32'h3C);
        exp_err_q.push_back(1'b0);
        @(posedge clk);
        #1 req = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ack && t < 20);
        check("respond_reached", 32'(ack), 32'd1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_respond_ack", 32'(ack), 32'd0);
        check("rst_in_respond_q", 32'(q), 32'd0);
        rst_n = 1'b1;
        txn(1'b0, 5'd7, 8'h00, 1'b0, 8'h3C, 1'b0, "rd7_kept");

        // 5: parity test hook
        txn(1'b1, 5'd9, 8'h01, 1'b1, 8'h01, 1'b0, "wr9_flip");
        txn(1'b0, 5'd9, 8'h00, 1'b0, 8'h01, PAR_EXP, "rd9_bad");
        txn(1'b1, 5'd9, 8'h01, 1'b0, 8'h01, 1'b0, "wr9_ok");
        txn(1'b0, 5'd9, 8'h00, 1'b0, 8'h01, 1'b0, "rd9_ok");

        // Address 31 on the main instance (top of the array)
        txn(1'b0, 5'd31, 8'h00, 1'b0, 8'd31, 1'b0, "rd31");

        // 6: LATENCY=1 instance
        @(negedge clk);
        req1  = 1'b1;
        addr1 = 5'd31;
        @(posedge clk);
        #1 req1 = 1'b0;
        @(negedge clk);
        check("l1_ack_early", 32'(ack1), 32'd0);
        check("l1_busy", 32'(ready1), 32'd0);
        @(negedge clk);
        check("l1_ack", 32'(ack1), 32'd1);
        check("l1_q", 32'(q1), 32'd31);
        check("l1_err", 32'(err1), 32'd0);
        @(negedge clk);
        check("l1_ack_single", 32'(ack1), 32'd0);
        check("l1_ready_after", 32'(ready1), 32'd1);
        check("l1_q_hold", 32'(q1), 32'd31);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
